// File: rtl/not_not_pkg.sv
// Shared definitions for the Not-Not round controller: op encoding, FSM states
// and maximal-length LFSR tap masks.
package not_not_pkg;

  localparam logic [1:0] OP_A   = 2'd0;
  localparam logic [1:0] OP_AND = 2'd1;
  localparam logic [1:0] OP_OR  = 2'd2;
  localparam logic [1:0] OP_B   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GEN   = 2'd1,
    ST_ARMED = 2'd2,
    ST_OVER  = 2'd3
  } state_e;

  // Fibonacci XOR tap masks (bit i set = stage i+1 feeds back), widths 8..16.
  function automatic logic [15:0] lfsr_taps(input int width);
    case (width)
      8:       return 16'h00B8;
      9:       return 16'h0110;
      10:      return 16'h0240;
      11:      return 16'h0500;
      12:      return 16'h0829;
      13:      return 16'h100D;
      14:      return 16'h2015;
      15:      return 16'h6000;
      default: return 16'hD008;
    endcase
  endfunction

endpackage

// File: rtl/not_not_round_ctrl_if.sv
// Board-side bundle of the round controller: player/debug inputs and the
// prompt, verdict and score outputs consumed by the display logic.
interface not_not_round_ctrl_if #(
  parameter int N_COLORS    = 4,
  parameter int MAX_NOTS    = 3,
  parameter int SCORE_WIDTH = 8
);
  localparam int CW = $clog2(N_COLORS);
  localparam int NW = $clog2(MAX_NOTS + 1);
  localparam int PW = NW + 2 + 2 * CW;

  logic                   start;
  logic                   answer_valid;
  logic [N_COLORS-1:0]    answer;
  logic                   dbg_load;
  logic [PW-1:0]          dbg_prompt;
  logic                   prompt_valid;
  logic [NW-1:0]          not_count;
  logic [1:0]             op;
  logic [CW-1:0]          color_a;
  logic [CW-1:0]          color_b;
  logic [N_COLORS-1:0]    expected;
  logic [SCORE_WIDTH-1:0] score;
  logic [3:0]             lives;
  logic                   correct;
  logic                   wrong;
  logic                   timeout;
  logic                   game_over;

  modport master (
    output start, answer_valid, answer, dbg_load, dbg_prompt,
    input  prompt_valid, not_count, op, color_a, color_b, expected,
           score, lives, correct, wrong, timeout, game_over
  );

  modport slave (
    input  start, answer_valid, answer, dbg_load, dbg_prompt,
    output prompt_valid, not_count, op, color_a, color_b, expected,
           score, lives, correct, wrong, timeout, game_over
  );

endinterface

// File: rtl/lfsr_n.sv
// Free-running Fibonacci LFSR of selectable width; taps come from the package
// table so any width 8..16 is maximal length.
module lfsr_n
  import not_not_pkg::*;
#(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] SEED  = '1
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             enable,
  output logic [WIDTH-1:0] lfsr_out
);

  localparam logic [WIDTH-1:0] TAPS = WIDTH'(lfsr_taps(WIDTH));

  logic [WIDTH-1:0] lfsr_q;
  logic [WIDTH-1:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (enable) begin
      lfsr_d = {lfsr_q[WIDTH-2:0], ^(lfsr_q & TAPS)};
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign lfsr_out = lfsr_q;

endmodule

// File: rtl/not_not_round_ctrl.sv
// Not-Not round controller: draws a prompt, times the answer window, judges
// the one-hot answer and keeps score, lives and game-over.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | after reset, waiting for start
// ST_GEN   | one cycle: latch prompt fields and expected mask, load timer
// ST_ARMED | prompt shown, timer counting down, waiting for an answer
// ST_OVER  | lives exhausted, score frozen, waiting for start
module not_not_round_ctrl
  import not_not_pkg::*;
#(
  parameter int          N_COLORS       = 4,
  parameter int          MAX_NOTS       = 3,
  parameter int          LFSR_WIDTH     = 16,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1,
  parameter int          TIMEOUT_CYCLES = 50_000_000,
  parameter int          LIVES          = 3,
  parameter int          SCORE_WIDTH    = 8
) (
  input logic                  clock,
  input logic                  resetn,
  not_not_round_ctrl_if.slave  bus
);

  localparam int CW = $clog2(N_COLORS);
  localparam int NW = $clog2(MAX_NOTS + 1);
  localparam int PW = NW + 2 + 2 * CW;
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  state_e                 state_q, state_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic [NW-1:0]          not_count_q, not_count_d;
  logic [1:0]             op_q, op_d;
  logic [CW-1:0]          color_a_q, color_a_d;
  logic [CW-1:0]          color_b_q, color_b_d;
  logic [N_COLORS-1:0]    expected_q, expected_d;
  logic [SCORE_WIDTH-1:0] score_q, score_d;
  logic [3:0]             lives_q, lives_d;
  logic                   correct_q, correct_d;
  logic                   wrong_q, wrong_d;
  logic                   timeout_q, timeout_d;

  logic [LFSR_WIDTH-1:0]  lfsr_out;
  logic [15:0]            lfsr_ext;
  logic                   unused_lfsr_hi;

  logic [PW-1:0]          prompt_sel;
  logic [NW-1:0]          sel_nots;
  logic [1:0]             sel_op;
  logic [CW-1:0]          sel_a;
  logic [CW-1:0]          sel_b;
  logic [N_COLORS-1:0]    hot_a, hot_b, base_mask, mask_new;
  logic                   ans_onehot, ans_ok;
  logic                   resolve, good;

  lfsr_n #(
    .WIDTH (LFSR_WIDTH),
    .SEED  (LFSR_SEED[LFSR_WIDTH-1:0])
  ) u_lfsr (
    .clock    (clock),
    .resetn   (resetn),
    .enable   (1'b1),
    .lfsr_out (lfsr_out)
  );

  // Narrow LFSRs are zero-extended so wide prompts still have a source.
  assign lfsr_ext       = 16'(lfsr_out);
  assign unused_lfsr_hi = ^lfsr_ext[15:PW];

  always_comb begin
    prompt_sel = bus.dbg_load ? bus.dbg_prompt : lfsr_ext[PW-1:0];
    {sel_nots, sel_op, sel_a, sel_b} = prompt_sel;
    hot_a = N_COLORS'(1) << sel_a;
    hot_b = N_COLORS'(1) << sel_b;
    case (sel_op)
      OP_A:    base_mask = hot_a;
      OP_AND:  base_mask = hot_a & hot_b;
      OP_OR:   base_mask = hot_a | hot_b;
      default: base_mask = hot_b;
    endcase
    mask_new = sel_nots[0] ? ~base_mask : base_mask;
  end

  always_comb begin
    ans_onehot = (bus.answer != '0) &&
                 ((bus.answer & (bus.answer - N_COLORS'(1))) == '0);
    ans_ok     = (expected_q != '0) && ans_onehot &&
                 ((bus.answer & expected_q) != '0);
  end

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    not_count_d = not_count_q;
    op_d        = op_q;
    color_a_d   = color_a_q;
    color_b_d   = color_b_q;
    expected_d  = expected_q;
    score_d     = score_q;
    lives_d     = lives_q;
    correct_d   = 1'b0;
    wrong_d     = 1'b0;
    timeout_d   = 1'b0;
    resolve     = 1'b0;
    good        = 1'b0;

    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (bus.start) begin
          score_d = '0;
          lives_d = 4'(LIVES);
          state_d = ST_GEN;
        end
      end
      ST_GEN: begin
        not_count_d = sel_nots;
        op_d        = sel_op;
        color_a_d   = sel_a;
        color_b_d   = sel_b;
        expected_d  = mask_new;
        timer_d     = TW'(TIMEOUT_CYCLES - 1);
        state_d     = ST_ARMED;
      end
      ST_ARMED: begin
        // A player answer on the terminal-count cycle takes priority.
        if (bus.answer_valid) begin
          resolve = 1'b1;
          good    = ans_ok;
        end else if (timer_q == '0) begin
          resolve   = 1'b1;
          good      = (expected_q == '0);
          timeout_d = 1'b1;
        end else begin
          timer_d = timer_q - TW'(1);
        end
        if (resolve) begin
          if (good) begin
            correct_d = 1'b1;
            if (score_q != {SCORE_WIDTH{1'b1}}) begin
              score_d = score_q + SCORE_WIDTH'(1);
            end
            state_d = ST_GEN;
          end else begin
            wrong_d = 1'b1;
            lives_d = lives_q - 4'd1;
            state_d = (lives_q == 4'd1) ? ST_OVER : ST_GEN;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      not_count_q <= '0;
      op_q        <= '0;
      color_a_q   <= '0;
      color_b_q   <= '0;
      expected_q  <= '0;
      score_q     <= '0;
      lives_q     <= 4'(LIVES);
      correct_q   <= 1'b0;
      wrong_q     <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      not_count_q <= not_count_d;
      op_q        <= op_d;
      color_a_q   <= color_a_d;
      color_b_q   <= color_b_d;
      expected_q  <= expected_d;
      score_q     <= score_d;
      lives_q     <= lives_d;
      correct_q   <= correct_d;
      wrong_q     <= wrong_d;
      timeout_q   <= timeout_d;
    end
  end

  assign bus.prompt_valid = (state_q == ST_ARMED);
  assign bus.game_over    = (state_q == ST_OVER);
  assign bus.not_count    = not_count_q;
  assign bus.op           = op_q;
  assign bus.color_a      = color_a_q;
  assign bus.color_b      = color_b_q;
  assign bus.expected     = expected_q;
  assign bus.score        = score_q;
  assign bus.lives        = lives_q;
  assign bus.correct      = correct_q;
  assign bus.wrong        = wrong_q;
  assign bus.timeout      = timeout_q;

endmodule
